// File: rtl/uncached_loader_pkg.sv
// Shared definitions for the uncached load/store AXI initiators:
// FSM state encoding, fixed AR/AW field values and per-path AXI IDs.
package uncached_loader_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WAIT_GRNT = 3'd1,
    ADDR      = 3'd2,
    DATA      = 3'd3,
    DONE      = 3'd4
  } state_e;

  localparam logic [3:0] AXI_LEN_SINGLE  = 4'b0000;
  localparam logic [2:0] AXI_SIZE_WORD   = 3'b010;
  localparam logic [1:0] AXI_BURST_FIXED = 2'b00;
  localparam logic [1:0] AXI_LOCK_NONE   = 2'b00;
  localparam logic [3:0] AXI_CACHE_NONE  = 4'b0000;
  localparam logic [2:0] AXI_PROT_NONE   = 3'b000;

  localparam logic [3:0] AXI_ID_STORE = 4'b0010;
  localparam logic [3:0] AXI_ID_LOAD  = 4'b0011;

endpackage

// File: rtl/uncached_loader.sv
// Uncached load initiator for the MEM stage.
// Arbitrates for the shared AXI bus (req/grnt), issues one single-beat
// word-aligned read with ARID=LOAD_ID, captures the matching RDATA and
// stalls the pipeline until the word is available (one cycle in DONE).
// Ports:
//   clk, rst_n                      clock, synchronous active-low reset
//   uncachedLoader_req/grnt         arbiter handshake
//   uncachedLoader_ar*              AXI read address channel
//   uncachedLoader_r*               AXI read data channel (rresp ignored)
//   uncachedLoader_cpu_*            CPU side: request, address, word, stalls
module uncached_loader
  import uncached_loader_pkg::*;
#(
  parameter logic [3:0] LOAD_ID = AXI_ID_LOAD
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        uncachedLoader_req,
  input  logic        uncachedLoader_grnt,
  output logic [3:0]  uncachedLoader_arid,
  output logic [31:0] uncachedLoader_araddr,
  output logic [3:0]  uncachedLoader_arlen,
  output logic [2:0]  uncachedLoader_arsize,
  output logic [1:0]  uncachedLoader_arburst,
  output logic [1:0]  uncachedLoader_arlock,
  output logic [3:0]  uncachedLoader_arcache,
  output logic [2:0]  uncachedLoader_arprot,
  output logic        uncachedLoader_arvalid,
  input  logic        uncachedLoader_arready,
  input  logic [3:0]  uncachedLoader_rid,
  input  logic [31:0] uncachedLoader_rdata,
  input  logic [1:0]  uncachedLoader_rresp,
  input  logic        uncachedLoader_rlast,
  input  logic        uncachedLoader_rvalid,
  output logic        uncachedLoader_rready,
  input  logic        uncachedLoader_cpu_uncached,
  input  logic        uncachedLoader_cpu_re,
  input  logic [31:0] uncachedLoader_cpu_addr,
  output logic [31:0] uncachedLoader_cpu_rdata,
  output logic        uncachedLoader_cpu_Stall,
  output logic        uncachedLoader_cpu_PC_Stall
);

  state_e      state_q, state_d;
  logic        req_q, req_d;
  logic        arvalid_q, arvalid_d;
  logic        rready_q, rready_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] rdata_q, rdata_d;

  logic need_read;
  logic beat_ok;

  // rresp is deliberately not checked; low address bits are dropped by alignment.
  logic unused_inputs;
  assign unused_inputs = ^{uncachedLoader_rresp, uncachedLoader_cpu_addr[1:0]};

  assign need_read = uncachedLoader_cpu_uncached & uncachedLoader_cpu_re;
  assign beat_ok   = uncachedLoader_rvalid & rready_q & uncachedLoader_rlast &
                     (uncachedLoader_rid == LOAD_ID);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      req_q     <= 1'b0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      addr_q    <= '0;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      req_q     <= req_d;
      arvalid_q <= arvalid_d;
      rready_q  <= rready_d;
      addr_q    <= addr_d;
      rdata_q   <= rdata_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    req_d     = req_q;
    arvalid_d = arvalid_q;
    rready_d  = rready_q;
    addr_d    = addr_q;
    rdata_d   = rdata_q;
    unique case (state_q)
      IDLE: begin
        if (need_read) begin
          addr_d  = {uncachedLoader_cpu_addr[31:2], 2'b00};
          req_d   = 1'b1;
          state_d = WAIT_GRNT;
        end else begin
          req_d     = 1'b0;
          arvalid_d = 1'b0;
          rready_d  = 1'b0;
        end
      end
      WAIT_GRNT: begin
        if (uncachedLoader_grnt) begin
          arvalid_d = 1'b1;
          state_d   = ADDR;
        end
      end
      ADDR: begin
        if (uncachedLoader_arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = DATA;
        end
      end
      DATA: begin
        // Beats carrying another initiator's ID are consumed without capture.
        if (beat_ok) begin
          rdata_d  = uncachedLoader_rdata;
          rready_d = 1'b0;
          state_d  = DONE;
        end
      end
      DONE: begin
        req_d   = 1'b0;
        state_d = IDLE;
      end
      default: begin
        state_d   = IDLE;
        req_d     = 1'b0;
        arvalid_d = 1'b0;
        rready_d  = 1'b0;
      end
    endcase
  end

  assign uncachedLoader_req          = req_q;
  assign uncachedLoader_arid         = LOAD_ID;
  assign uncachedLoader_araddr       = addr_q;
  assign uncachedLoader_arlen        = AXI_LEN_SINGLE;
  assign uncachedLoader_arsize       = AXI_SIZE_WORD;
  assign uncachedLoader_arburst      = AXI_BURST_FIXED;
  assign uncachedLoader_arlock       = AXI_LOCK_NONE;
  assign uncachedLoader_arcache      = AXI_CACHE_NONE;
  assign uncachedLoader_arprot       = AXI_PROT_NONE;
  assign uncachedLoader_arvalid      = arvalid_q;
  assign uncachedLoader_rready       = rready_q;
  assign uncachedLoader_cpu_rdata    = rdata_q;
  assign uncachedLoader_cpu_Stall    = ~(((state_q == IDLE) & ~need_read) | (state_q == DONE));
  assign uncachedLoader_cpu_PC_Stall = uncachedLoader_cpu_Stall;

endmodule

// File: tb/tb_uncached_loader.sv
// Scoreboard bench for uncached_loader: tests push expected AR addresses and
// load words into queues; a monitor pops and compares on AR handshakes and on
// load completion (stall low while an uncached load is requested).
module tb_uncached_loader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req, grnt;
  logic [3:0]  arid, arlen, arcache;
  logic [31:0] araddr;
  logic [2:0]  arsize, arprot;
  logic [1:0]  arburst, arlock;
  logic        arvalid, arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast, rvalid, rready;
  logic        cpu_uncached, cpu_re;
  logic [31:0] cpu_addr, cpu_rdata;
  logic        cpu_stall, cpu_pc_stall;

  always #5 clk = ~clk;

  uncached_loader #(.LOAD_ID(4'b0011)) dut (
    .clk                         (clk),
    .rst_n                       (rst_n),
    .uncachedLoader_req          (req),
    .uncachedLoader_grnt         (grnt),
    .uncachedLoader_arid         (arid),
    .uncachedLoader_araddr       (araddr),
    .uncachedLoader_arlen        (arlen),
    .uncachedLoader_arsize       (arsize),
    .uncachedLoader_arburst      (arburst),
    .uncachedLoader_arlock       (arlock),
    .uncachedLoader_arcache      (arcache),
    .uncachedLoader_arprot       (arprot),
    .uncachedLoader_arvalid      (arvalid),
    .uncachedLoader_arready      (arready),
    .uncachedLoader_rid          (rid),
    .uncachedLoader_rdata        (rdata),
    .uncachedLoader_rresp        (rresp),
    .uncachedLoader_rlast        (rlast),
    .uncachedLoader_rvalid       (rvalid),
    .uncachedLoader_rready       (rready),
    .uncachedLoader_cpu_uncached (cpu_uncached),
    .uncachedLoader_cpu_re       (cpu_re),
    .uncachedLoader_cpu_addr     (cpu_addr),
    .uncachedLoader_cpu_rdata    (cpu_rdata),
    .uncachedLoader_cpu_Stall    (cpu_stall),
    .uncachedLoader_cpu_PC_Stall (cpu_pc_stall)
  );

  int unsigned errors = 0;
  int unsigned checks = 0;

  logic [31:0] q_ar[$];
  logic [31:0] q_rd[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Bus slave: grant and arready after configurable delays, R beats from a list.
  int          grnt_dly = 0;
  int          ar_dly   = 0;
  int          gcnt, acnt, bidx;
  logic        rr_prev;
  logic [3:0]  b_id[$];
  logic [31:0] b_data[$];

  initial begin
    grnt = 1'b0; arready = 1'b0; rvalid = 1'b0; rid = '0; rdata = '0;
    rlast = 1'b0; rresp = 2'b10; gcnt = 0; acnt = 0; bidx = 0; rr_prev = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (req) begin
        grnt = (gcnt >= grnt_dly);
        gcnt++;
      end else begin
        grnt = 1'b0;
        gcnt = 0;
      end
      if (arvalid) begin
        arready = (acnt >= ar_dly);
        acnt++;
      end else begin
        arready = 1'b0;
        acnt = 0;
      end
      if (rvalid && rr_prev) bidx++;
      rr_prev = rready;
      if (rready && bidx < b_id.size()) begin
        rvalid = 1'b1;
        rid    = b_id[bidx];
        rdata  = b_data[bidx];
        rlast  = 1'b1;
      end else begin
        rvalid = 1'b0;
        rlast  = 1'b0;
      end
    end
  end

  // Monitor / scoreboard.
  logic        arv_pend = 1'b0;
  logic [31:0] pend_addr = '0;

  initial begin
    logic [31:0] e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        arv_pend = 1'b0;
      end else begin
        if (arv_pend) begin
          check("ar_hold_valid", {31'd0, arvalid}, 32'd1);
          check("ar_hold_addr", araddr, pend_addr);
        end
        if (arvalid && arready) begin
          if (q_ar.size() == 0) begin
            checks++; errors++;
            $display("FAIL ar_unexpected: got araddr %h expected no AR traffic", araddr);
          end else begin
            e = q_ar.pop_front();
            check("ar_addr", araddr, e);
            check("ar_fields", {10'd0, arid, arlen, arsize, arburst, arlock, arcache, arprot},
                  {10'd0, 4'b0011, 4'b0000, 3'b010, 2'b00, 2'b00, 4'b0000, 3'b000});
          end
        end
        arv_pend  = arvalid && !arready;
        pend_addr = araddr;
        if (cpu_re && cpu_uncached && !cpu_stall) begin
          if (q_rd.size() == 0) begin
            checks++; errors++;
            $display("FAIL rd_unexpected: got cpu_rdata %h expected no completion", cpu_rdata);
          end else begin
            e = q_rd.pop_front();
            check("cpu_rdata", cpu_rdata, e);
          end
          check("pc_stall_eq", {31'd0, cpu_pc_stall}, {31'd0, cpu_stall});
        end
      end
    end
  end

  task automatic do_load(input string name, input logic [31:0] addr, input logic [31:0] exp_ar,
                         input int gd, input int ad,
                         input logic [3:0] id0, input logic [31:0] d0,
                         input bit two, input logic [3:0] id1, input logic [31:0] d1,
                         input logic [31:0] exp_data, input int exp_lat);
    int c;
    grnt_dly = gd;
    ar_dly   = ad;
    b_id.delete();
    b_data.delete();
    bidx = 0;
    b_id.push_back(id0);
    b_data.push_back(d0);
    if (two) begin
      b_id.push_back(id1);
      b_data.push_back(d1);
    end
    q_ar.push_back(exp_ar);
    q_rd.push_back(exp_data);
    @(posedge clk); #1;
    cpu_addr = addr; cpu_uncached = 1'b1; cpu_re = 1'b1;
    c = 0;
    forever begin
      @(negedge clk);
      if (!cpu_stall) break;
      c++;
      if (c > 60) break;
    end
    check({name, "_latency"}, c, exp_lat);
  endtask

  task automatic go_idle(input int n);
    @(posedge clk); #1;
    cpu_re = 1'b0;
    repeat (n) begin
      @(negedge clk);
      check("idle_req", {31'd0, req}, 32'd0);
      check("idle_stall", {31'd0, cpu_stall}, 32'd0);
    end
  endtask

  initial begin
    int c;
    rst_n = 1'b0; cpu_uncached = 1'b0; cpu_re = 1'b0; cpu_addr = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_req", {31'd0, req}, 32'd0);
    check("rst_arvalid", {31'd0, arvalid}, 32'd0);
    check("rst_rready", {31'd0, rready}, 32'd0);
    check("rst_rdata", cpu_rdata, 32'h0);
    check("rst_araddr", araddr, 32'h0);
    check("rst_stall", {31'd0, cpu_stall}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    do_load("zero_wait", 32'hBFAF_8004, 32'hBFAF_8004, 0, 0,
            4'b0011, 32'h1234_5678, 1'b0, 4'b0, 32'h0, 32'h1234_5678, 4);
    // Back-to-back: re stays high through IDLE.
    do_load("delayed", 32'h8000_0010, 32'h8000_0010, 3, 2,
            4'b0011, 32'h5555_AAAA, 1'b0, 4'b0, 32'h0, 32'h5555_AAAA, 9);
    go_idle(2);
    check("rdata_hold", cpu_rdata, 32'h5555_AAAA);

    do_load("wrong_id", 32'h0000_1000, 32'h0000_1000, 0, 0,
            4'b0001, 32'hDEAD_BEEF, 1'b1, 4'b0011, 32'h0000_00AA, 32'h0000_00AA, 5);
    do_load("unaligned", 32'h1FD0_F003, 32'h1FD0_F000, 0, 0,
            4'b0011, 32'hCAFE_F00D, 1'b0, 4'b0, 32'h0, 32'hCAFE_F00D, 4);
    go_idle(1);

    // Cached load, then uncached non-load: no bus activity.
    @(posedge clk); #1;
    cpu_uncached = 1'b0; cpu_re = 1'b1; cpu_addr = 32'h0000_4000;
    repeat (4) begin
      @(negedge clk);
      check("cached_req", {31'd0, req}, 32'd0);
      check("cached_stall", {31'd0, cpu_stall}, 32'd0);
    end
    @(posedge clk); #1;
    cpu_uncached = 1'b1; cpu_re = 1'b0;
    repeat (4) begin
      @(negedge clk);
      check("nonload_req", {31'd0, req}, 32'd0);
      check("nonload_stall", {31'd0, cpu_stall}, 32'd0);
    end

    // Reset while waiting in DATA; slave never returns a beat.
    grnt_dly = 0; ar_dly = 0;
    b_id.delete(); b_data.delete(); bidx = 0;
    q_ar.push_back(32'h0000_2000);
    @(posedge clk); #1;
    cpu_addr = 32'h0000_2002; cpu_uncached = 1'b1; cpu_re = 1'b1;
    c = 0;
    forever begin
      @(negedge clk);
      if (rready) break;
      c++;
      if (c > 20) break;
    end
    check("rst_reach_data", {31'd0, rready}, 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b0; cpu_re = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("mid_rst_req", {31'd0, req}, 32'd0);
    check("mid_rst_arvalid", {31'd0, arvalid}, 32'd0);
    check("mid_rst_rready", {31'd0, rready}, 32'd0);
    check("mid_rst_stall", {31'd0, cpu_stall}, 32'd0);

    do_load("after_rst", 32'h0000_3008, 32'h0000_3008, 0, 0,
            4'b0011, 32'h0BAD_F00D, 1'b0, 4'b0, 32'h0, 32'h0BAD_F00D, 4);
    go_idle(2);
    check("q_ar_drained", q_ar.size(), 32'd0);
    check("q_rd_drained", q_rd.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uncached_loader.md
Name: uncached_loader

Overview:
- AXI read-channel initiator for uncached CPU loads in the MEM stage; the read-side counterpart of the uncached store path.
- Requests the shared AXI bus through the arbiter (req/grnt) and issues one single-beat, word-aligned read.
- Captures the returned word, stalls the pipeline until the data is available, then presents the word for one cycle.
- Byte/halfword extraction and sign extension stay in the MEM stage; this block returns the raw 32-bit word.

Parameters:
- LOAD_ID, 4'b0011, AXI ARID used on issue and RID matched on return (distinct from the store ID 4'b0010).

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- uncachedLoader_req  out  1  bus request to arbiter
- uncachedLoader_grnt  in  1  bus grant from arbiter
- uncachedLoader_arid  out  4  = LOAD_ID
- uncachedLoader_araddr  out  32  latched {addr[31:2],2'b0}
- uncachedLoader_arlen  out  4  4'b0000
- uncachedLoader_arsize  out  3  3'b010
- uncachedLoader_arburst  out  2  2'b00
- uncachedLoader_arlock  out  2  2'b00
- uncachedLoader_arcache  out  4  4'b0000
- uncachedLoader_arprot  out  3  3'b000
- uncachedLoader_arvalid  out  1  read address valid
- uncachedLoader_arready  in  1  read address ready
- uncachedLoader_rid  in  4  read data ID
- uncachedLoader_rdata  in  32  read data
- uncachedLoader_rresp  in  2  read response (ignored)
- uncachedLoader_rlast  in  1  last beat
- uncachedLoader_rvalid  in  1  read data valid
- uncachedLoader_rready  out  1  read data ready
- uncachedLoader_cpu_uncached  in  1  access is uncached
- uncachedLoader_cpu_re  in  1  load request
- uncachedLoader_cpu_addr  in  32  load address
- uncachedLoader_cpu_rdata  out  32  captured word
- uncachedLoader_cpu_Stall  out  1  stall MEM stage
- uncachedLoader_cpu_PC_Stall  out  1  stall PC; identical to cpu_Stall

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-low on rst_n.
- Reset values: state = IDLE; req, arvalid and rready are 0; the address latch and cpu_rdata are 32'h0.
- need_read = cpu_uncached & cpu_re.
- Stall is combinational: cpu_Stall = ~((state==IDLE & ~need_read) | state==DONE).
- IDLE:
  - If need_read: latch {cpu_addr[31:2],2'b0}, set req<=1, go to WAIT_GRNT.
  - Otherwise: drive req, arvalid and rready to 0 and stay in IDLE.
- WAIT_GRNT: on grnt, set arvalid<=1 and go to ADDR. Otherwise hold.
- ADDR:
  - arvalid stays 1 until it is accepted.
  - On arready: set arvalid<=0, rready<=1, go to DATA.
  - araddr and all other AR fields are stable while arvalid=1.
- DATA:
  - On rvalid & rready & rid==LOAD_ID & rlast: capture rdata into cpu_rdata, set rready<=0, go to DONE.
  - A beat with rvalid but a non-matching RID is ignored, and the block stays in DATA.
  - rresp is not checked; the data is captured regardless.
- DONE:
  - Stall is 0 for exactly one cycle; cpu_rdata is valid in this cycle.
  - Set req<=0, go to IDLE.
  - cpu_rdata holds its value until the next capture.
- Minimum latency, with grnt, arready and rvalid each asserted in the first cycle they are possible:
  - need_read seen in IDLE at cycle 0.
  - WAIT_GRNT at cycle 1, ADDR at cycle 2, DATA at cycle 3, DONE at cycle 4.
  - Stall is high in cycles 0–3 and low in cycle 4.
- Back-to-back loads: after DONE the block always passes through IDLE. If need_read is still high there, a new transaction starts and stall re-asserts the same cycle (the pipeline has advanced by then).
- req remains 1 from WAIT_GRNT through DONE, so the arbiter does not reassign the bus mid-transaction.
- Reset mid-operation: return to IDLE immediately and drop arvalid, rready and req. Any outstanding beat is not waited on.
- Invalid state encoding: recover to IDLE with all outputs deasserted.
- Simulation-only $display lines are permitted; they must be guarded so they do not synthesise.

Decomposition:
- Shared package: state encodings (IDLE=3'd0, WAIT_GRNT=3'd1, ADDR=3'd2, DATA=3'd3, DONE=3'd4).
- Also in the package: AXI constants (single-beat len, word size, fixed burst, zero lock/cache/prot) and the AXI ID assignments (store 4'b0010, load 4'b0011), shared with the uncached store path.
- No sub-module; a single FSM with a data latch is enough.

Test Plan:
- Zero-wait read: uncached=1, re=1, addr=32'hBFAF_8004; grnt, arready and rvalid (rid=4'b0011, rlast=1, rdata=32'h1234_5678) each high at first opportunity. Required: araddr=32'hBFAF_8004, stall low only at cycle 4, cpu_rdata=32'h1234_5678 at cycle 4.
- Delayed grant and arready: grnt after 3 cycles, arready after 2 more. Required: arvalid held stable with constant araddr until accepted; stall stays high throughout.
- Wrong-ID beat: in DATA, drive rvalid with rid=4'b0001, rdata=32'hDEAD_BEEF, then rid=4'b0011, rdata=32'h0000_00AA. Required: cpu_rdata=32'h0000_00AA; the first beat is ignored.
- Unaligned address: addr=32'h1FD0_F003. Required: araddr=32'h1FD0_F000, arsize=3'b010.
- Reset in DATA: assert rst_n=0 for one cycle. Required: next cycle state=IDLE, req, arvalid and rready all 0, stall=0 with re=0.
- Cached or non-load access: uncached=0 or re=0. Required: req stays 0, stall=0, no AR traffic.
